// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard inputs, pipeline-register controls and counters of the hazard controller
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 16);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             ex_memread;
    logic [4:0]       ex_rd;
    logic             mem_branch_taken;
    logic             mem_busy;
    logic             clear_counters;
    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_write;
    logic             ex_mem_write;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_flush;
    logic             timeout_err;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;
    modport master (
        output id_rs1, id_rs2, ex_memread, ex_rd, mem_branch_taken, mem_busy, clear_counters,
        input  pc_write, if_id_write, id_ex_write, ex_mem_write,
        input  if_id_flush, id_ex_flush, ex_mem_flush, timeout_err, stall_count, flush_count
    );
    modport slave (
        input  id_rs1, id_rs2, ex_memread, ex_rd, mem_branch_taken, mem_busy, clear_counters,
        output pc_write, if_id_write, id_ex_write, ex_mem_write,
        output if_id_flush, id_ex_flush, ex_mem_flush, timeout_err, stall_count, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush control for load-use, MEM branches and memory waits, with watchdog and counters
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input logic                 clk,
    input logic                 reset,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam int WAIT_W = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {RUN, WAIT, HALT} state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  flush_q, flush_d;
    logic              halt, lu, freeze, flush, bubble, normal, clr;

    // Priority: busy freezes everything, a taken branch beats a load-use hazard.
    always_comb begin
        halt   = state_q == HALT;
        lu     = bus.ex_memread && bus.ex_rd != 5'd0 &&
                 (bus.ex_rd == bus.id_rs1 || bus.ex_rd == bus.id_rs2);
        freeze = !reset && !halt && bus.mem_busy;
        flush  = !reset && !halt && !bus.mem_busy && bus.mem_branch_taken;
        bubble = !reset && !halt && !bus.mem_busy && !bus.mem_branch_taken && lu;
        normal = !reset && !halt && !bus.mem_busy && !bus.mem_branch_taken && !lu;
        clr    = bus.clear_counters && !halt;
        state_d   = halt ? HALT : freeze ? (wait_q == WAIT_LAST ? HALT : WAIT) : RUN;
        wait_d    = freeze ? wait_q + 1'b1 : '0;
        timeout_d = timeout_q || (freeze && wait_q == WAIT_LAST);
        stall_d   = clr ? '0 : ((freeze || bubble) && stall_q != CNT_MAX) ? stall_q + 1'b1 : stall_q;
        flush_d   = clr ? '0 : (flush && flush_q != CNT_MAX) ? flush_q + 1'b1 : flush_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RUN;
            wait_q    <= '0;
            timeout_q <= 1'b0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
        end
    end

    assign bus.pc_write     = flush || normal;
    assign bus.if_id_write  = flush || normal;
    assign bus.id_ex_write  = flush || bubble || normal;
    assign bus.ex_mem_write = flush || bubble || normal;
    assign bus.if_id_flush  = flush;
    assign bus.id_ex_flush  = flush || bubble;
    assign bus.ex_mem_flush = flush;
    assign bus.timeout_err  = timeout_q;
    assign bus.stall_count  = stall_q;
    assign bus.flush_count  = flush_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed vectors with hand-computed expectations for the hazard controller
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    pipeline_hazard_ctrl_if #(.CNT_W(4)) bus ();
    pipeline_hazard_ctrl #(.TIMEOUT(16), .CNT_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.id_rs1 = 5'd0;
        bus.id_rs2 = 5'd0;
        bus.ex_memread = 1'b0;
        bus.ex_rd = 5'd0;
        bus.mem_branch_taken = 1'b0;
        bus.mem_busy = 1'b0;
        bus.clear_counters = 1'b0;
    endtask

    task automatic load_use();
        bus.ex_memread = 1'b1;
        bus.ex_rd = 5'd5;
        bus.id_rs1 = 5'd3;
        bus.id_rs2 = 5'd5;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "time limit");
    end

    initial begin
        idle();
        reset = 1'b1;
        cyc();
        cyc();
        check("rst_pc_write", bus.pc_write, 1'b0);
        check("rst_id_ex_write", bus.id_ex_write, 1'b0);
        check("rst_stall", bus.stall_count, 4'd0);
        check("rst_timeout", bus.timeout_err, 1'b0);
        reset = 1'b0;
        #1;
        check("run_pc_write", bus.pc_write, 1'b1);
        check("run_flushes", {bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush}, 3'b000);

        load_use();
        #1;
        check("lu_pc_write", bus.pc_write, 1'b0);
        check("lu_if_id_write", bus.if_id_write, 1'b0);
        check("lu_id_ex_flush", bus.id_ex_flush, 1'b1);
        check("lu_ex_mem_write", {bus.id_ex_write, bus.ex_mem_write, bus.ex_mem_flush}, 3'b110);
        cyc();
        idle();
        #1;
        check("lu_next_en", {bus.pc_write, bus.if_id_write, bus.id_ex_write, bus.ex_mem_write}, 4'hf);
        check("lu_stall_count", bus.stall_count, 4'd1);

        bus.ex_memread = 1'b1;
        #1;
        check("x0_no_stall", bus.pc_write, 1'b1);
        bus.ex_memread = 1'b0;
        bus.ex_rd = 5'd7;
        bus.id_rs1 = 5'd7;
        #1;
        check("nonload_no_stall", bus.pc_write, 1'b1);
        cyc();
        check("x0_stall_count", bus.stall_count, 4'd1);

        do_reset();
        load_use();
        bus.mem_branch_taken = 1'b1;
        #1;
        check("br_lu_flushes", {bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush}, 3'b111);
        check("br_lu_pc_write", bus.pc_write, 1'b1);
        cyc();
        idle();
        #1;
        check("br_lu_flush_count", bus.flush_count, 4'd1);
        check("br_lu_stall_count", bus.stall_count, 4'd0);

        do_reset();
        bus.mem_busy = 1'b1;
        bus.mem_branch_taken = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("wait_frozen_%0d", i),
                  {bus.pc_write, bus.if_id_write, bus.id_ex_write, bus.ex_mem_write,
                   bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush}, 7'd0);
            cyc();
        end
        bus.mem_busy = 1'b0;
        #1;
        check("wait_then_flush", {bus.pc_write, bus.if_id_flush, bus.ex_mem_flush}, 3'b111);
        cyc();
        idle();
        #1;
        check("wait_stall_count", bus.stall_count, 4'd5);
        check("wait_flush_count", bus.flush_count, 4'd1);

        do_reset();
        bus.mem_busy = 1'b1;
        repeat (15) cyc();
        bus.mem_busy = 1'b0;
        #1;
        check("busy15_no_err", bus.timeout_err, 1'b0);
        check("busy15_running", bus.pc_write, 1'b1);
        check("busy15_stall_sat", bus.stall_count, 4'd15);
        cyc();
        bus.mem_busy = 1'b1;
        repeat (15) cyc();
        check("busy15b_no_err", bus.timeout_err, 1'b0);
        cyc();
        check("busy16_err", bus.timeout_err, 1'b1);
        bus.mem_busy = 1'b0;
        #1;
        check("halt_frozen", {bus.pc_write, bus.id_ex_write, bus.if_id_flush}, 3'b000);
        bus.mem_branch_taken = 1'b1;
        cyc();
        check("halt_flush_hold", bus.flush_count, 4'd0);
        check("halt_sticky", bus.timeout_err, 1'b1);
        reset = 1'b1;
        #1;
        check("halt_rst_err", bus.timeout_err, 1'b0);
        check("halt_rst_stall", bus.stall_count, 4'd0);
        check("halt_rst_pc_write", bus.pc_write, 1'b0);
        cyc();
        reset = 1'b0;
        #1;
        check("after_rst_run", bus.pc_write, 1'b1);

        idle();
        load_use();
        repeat (20) cyc();
        check("sat_stall", bus.stall_count, 4'd15);
        bus.clear_counters = 1'b1;
        cyc();
        check("clear_stall", bus.stall_count, 4'd0);
        bus.clear_counters = 1'b0;
        cyc();
        check("post_clear_stall", bus.stall_count, 4'd1);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
